// File: rtl/matrix_pkg.sv
// Shared constants for the FP8 3x3 matrix datapath: operand width, FP8 field
// positions and the operand loader state encoding.
package matrix_pkg;

   localparam int unsigned DATA_W   = 8;
   localparam int unsigned N_ELEMS  = 9;
   localparam int unsigned N_OPS    = 2 * N_ELEMS;
   localparam int unsigned IDX_W    = 5;

   // FP8: sign[7], exp[6:4] biased by 3, man[3:0]
   localparam int unsigned SIGN_BIT = 7;
   localparam int unsigned EXP_MSB  = 6;
   localparam int unsigned EXP_LSB  = 4;
   localparam int unsigned MAN_MSB  = 3;
   localparam int unsigned MAN_LSB  = 0;
   localparam int unsigned EXP_BIAS = 3;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OPS - 1);

   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } load_state_t;

endpackage

// File: rtl/matrix_operand_loader_if.sv
// Byte-serial operand stream (valid/ready with frame delimiter) feeding
// matrix_operand_loader.
interface matrix_operand_loader_if #(
   parameter int unsigned DATA_W = 8
) ();
   logic [DATA_W-1:0] s_data;
   logic              s_valid;
   logic              s_ready;
   logic              s_last;

   modport master (output s_data, s_valid, s_last, input s_ready);
   modport slave  (input s_data, s_valid, s_last, output s_ready);
endinterface

// File: rtl/matrix_operand_bank.sv
// 18-entry operand register bank: indexed single-port write, all entries
// exposed as the multiplier's named a00..b22 inputs.
module matrix_operand_bank
   import matrix_pkg::*;
#(
   parameter int unsigned DATA_W = matrix_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [IDX_W-1:0]  widx,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] a00, a01, a02, a10, a11, a12, a20, a21, a22,
   output logic [DATA_W-1:0] b00, b01, b02, b10, b11, b12, b20, b21, b22
);

   logic [N_OPS-1:0][DATA_W-1:0] mem;

   for (genvar g = 0; g < N_OPS; g++) begin : g_elem
      logic [DATA_W-1:0] q;
      always_ff @(posedge clk) begin
         if (reset)                              q <= '0;
         else if (we && (widx == IDX_W'(g)))     q <= wdata;
      end
      assign mem[g] = q;
   end

   // Index order is A row-major (0..8) then B row-major (9..17).
   assign a00 = mem[0];   assign a01 = mem[1];   assign a02 = mem[2];
   assign a10 = mem[3];   assign a11 = mem[4];   assign a12 = mem[5];
   assign a20 = mem[6];   assign a21 = mem[7];   assign a22 = mem[8];
   assign b00 = mem[9];   assign b01 = mem[10];  assign b02 = mem[11];
   assign b10 = mem[12];  assign b11 = mem[13];  assign b12 = mem[14];
   assign b20 = mem[15];  assign b21 = mem[16];  assign b22 = mem[17];

endmodule

// File: rtl/matrix_operand_loader.sv
// Collects 18 FP8 operand bytes, holds them for matrix_multiplier and runs the
// start/done handshake. Define MATRIX_LOADER_FRAME_CHECK_EN to enforce s_last framing.
module matrix_operand_loader
   import matrix_pkg::*;
#(
   parameter int unsigned DATA_W       = matrix_pkg::DATA_W,
   parameter int unsigned DONE_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   matrix_operand_loader_if.slave s,
   input  logic              done,
   output logic              start,
   output logic [DATA_W-1:0] a00, a01, a02, a10, a11, a12, a20, a21, a22,
   output logic [DATA_W-1:0] b00, b01, b02, b10, b11, b12, b20, b21, b22,
   output logic              busy,
   output logic              timeout,
   output logic              err
);

   localparam int unsigned CNT_W = (DONE_TIMEOUT < 2) ? 1 : $clog2(DONE_TIMEOUT + 1);

   load_state_t       state, state_d;
   logic [IDX_W-1:0]  idx, idx_d;
   logic [CNT_W-1:0]  wait_cnt, wait_cnt_d;
   logic              accept, frame_err, expired;
   logic              wr_en, timeout_d, err_d;

   assign s.s_ready = (state == ST_LOAD) && !reset;
   assign accept    = s.s_valid && s.s_ready;
   assign expired   = (DONE_TIMEOUT != 0) && ((32'(wait_cnt) + 32'd1) == DONE_TIMEOUT);

`ifdef MATRIX_LOADER_FRAME_CHECK_EN
   // s_last must mark exactly the 18th byte; anything else drops the byte.
   assign frame_err = (s.s_last && (idx != LAST_IDX)) || (!s.s_last && (idx == LAST_IDX));
`else
   assign frame_err = 1'b0;
`endif

   always_comb begin
      state_d    = state;
      idx_d      = idx;
      wait_cnt_d = wait_cnt;
      wr_en      = 1'b0;
      timeout_d  = 1'b0;
      err_d      = 1'b0;
      unique case (state)
         ST_LOAD: begin
            wait_cnt_d = '0;
            if (accept) begin
               if (frame_err) begin
                  idx_d = '0;
                  err_d = 1'b1;
               end else if (idx == LAST_IDX) begin
                  wr_en   = 1'b1;
                  idx_d   = '0;
                  state_d = ST_RUN;
               end else begin
                  wr_en = 1'b1;
                  idx_d = idx + IDX_W'(1);
               end
            end
         end
         ST_RUN: begin
            // done in the expiry cycle takes priority over the timeout
            if (done) begin
               state_d = ST_DRAIN;
            end else if (expired) begin
               timeout_d = 1'b1;
               state_d   = ST_LOAD;
            end else begin
               wait_cnt_d = wait_cnt + CNT_W'(1);
            end
         end
         ST_DRAIN: begin
            if (!done) state_d = ST_LOAD;
         end
         default: state_d = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_LOAD;
         idx      <= '0;
         wait_cnt <= '0;
         start    <= 1'b0;
         busy     <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         state    <= state_d;
         idx      <= idx_d;
         wait_cnt <= wait_cnt_d;
         start    <= (state_d == ST_RUN);
         busy     <= (state_d != ST_LOAD);
         timeout  <= timeout_d;
      end
   end

`ifdef MATRIX_LOADER_FRAME_CHECK_EN
   always_ff @(posedge clk) begin
      if (reset) err <= 1'b0;
      else       err <= err_d;
   end
`else
   assign err = 1'b0;
   logic unused_cfg;
   assign unused_cfg = ^{s.s_last, err_d};
`endif

   matrix_operand_bank #(.DATA_W(DATA_W)) u_bank (
      .clk   (clk),
      .reset (reset),
      .we    (wr_en),
      .widx  (idx),
      .wdata (s.s_data),
      .a00 (a00), .a01 (a01), .a02 (a02),
      .a10 (a10), .a11 (a11), .a12 (a12),
      .a20 (a20), .a21 (a21), .a22 (a22),
      .b00 (b00), .b01 (b01), .b02 (b02),
      .b10 (b10), .b11 (b11), .b12 (b12),
      .b20 (b20), .b21 (b21), .b22 (b22)
   );

endmodule

// File: tb/tb_matrix_operand_loader.sv
// Directed bench for matrix_operand_loader (DONE_TIMEOUT=4): reset, nominal
// load, sticky done, timeout and expiry-cycle done, gaps and framing.
module tb_matrix_operand_loader;
   import matrix_pkg::*;

   logic clk = 1'b0;
   logic reset, done;
   logic start, busy, timeout, err;
   logic [7:0] a00, a01, a02, a10, a11, a12, a20, a21, a22;
   logic [7:0] b00, b01, b02, b10, b11, b12, b20, b21, b22;
   logic [17:0][7:0] ops;

   int n_chk  = 0;
   int n_pass = 0;

   logic [7:0] nom [18] = '{8'h20, 8'h20, 8'h30, 8'h20, 8'h30, 8'hB8, 8'h90, 8'h20, 8'h30,
                            8'h30, 8'h44, 8'h44, 8'h30, 8'h30, 8'h30, 8'h30, 8'h20, 8'h20};
   logic [7:0] gv [18];
   logic [7:0] fv [18];

   matrix_operand_loader_if #(.DATA_W(8)) s_if ();

   matrix_operand_loader #(.DATA_W(8), .DONE_TIMEOUT(4)) dut (
      .clk (clk), .reset (reset), .s (s_if), .done (done), .start (start),
      .a00 (a00), .a01 (a01), .a02 (a02), .a10 (a10), .a11 (a11), .a12 (a12),
      .a20 (a20), .a21 (a21), .a22 (a22),
      .b00 (b00), .b01 (b01), .b02 (b02), .b10 (b10), .b11 (b11), .b12 (b12),
      .b20 (b20), .b21 (b21), .b22 (b22),
      .busy (busy), .timeout (timeout), .err (err)
   );

   assign ops = {b22, b21, b20, b12, b11, b10, b02, b01, b00,
                 a22, a21, a20, a12, a11, a10, a02, a01, a00};

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Called at a negedge; returns at the negedge after the byte is accepted.
   task automatic push(input logic [7:0] b, input logic last, input bit gap);
      int w = 0;
      s_if.s_data  = b;
      s_if.s_valid = 1'b1;
      s_if.s_last  = last;
      while (!s_if.s_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (w >= 50) check("push_stall", 32'(w), 32'd0);
      @(posedge clk);
      @(negedge clk);
      s_if.s_valid = 1'b0;
      s_if.s_last  = 1'b0;
      if (gap) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] v [18], input bit gap);
      for (int i = 0; i < 18; i++) push(v[i], (i == 17), gap);
   endtask

   task automatic check_ops(input string tag, input logic [7:0] v [18]);
      for (int i = 0; i < 18; i++) check($sformatf("%s[%0d]", tag, i), 32'(ops[i]), 32'(v[i]));
   endtask

   task automatic finish_run();
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 18; i++) begin
         gv[i] = 8'(i * 17 + 3);
         fv[i] = 8'(8'hA0 + i);
      end
      reset = 1'b1; done = 1'b0;
      s_if.s_valid = 1'b0; s_if.s_data = '0; s_if.s_last = 1'b0;

      // reset state
      @(negedge clk);
      check("rst_s_ready", 32'(s_if.s_ready), 32'd0);
      check("rst_start",   32'(start),   32'd0);
      check("rst_busy",    32'(busy),    32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      check("rst_err",     32'(err),     32'd0);
      check("rst_ops",     32'(|ops),    32'd0);
      reset = 1'b0;
      #1 check("rel_s_ready", 32'(s_if.s_ready), 32'd1);

      // reset mid-frame after 7 bytes
      for (int i = 0; i < 7; i++) push(nom[i], 1'b0, 1'b0);
      check("mid_a00", 32'(a00), 32'h20);
      check("mid_a20", 32'(a20), 32'h90);
      reset = 1'b1;
      #1 check("mid_rst_s_ready", 32'(s_if.s_ready), 32'd0);
      @(negedge clk);
      check("mid_rst_ops", 32'(|ops), 32'd0);
      reset = 1'b0;
      #1 check("mid_rel_s_ready", 32'(s_if.s_ready), 32'd1);

      // nominal frame
      send_frame(nom, 1'b0);
      check("nom_start",   32'(start), 32'd1);
      check("nom_busy",    32'(busy),  32'd1);
      check("nom_s_ready", 32'(s_if.s_ready), 32'd0);
      check_ops("nom", nom);
      @(negedge clk);
      check("nom_start_hold", 32'(start), 32'd1);
      done = 1'b1;
      @(negedge clk);
      check("nom_drain_start", 32'(start), 32'd0);
      check("nom_drain_busy",  32'(busy),  32'd1);
      check("nom_drain_rdy",   32'(s_if.s_ready), 32'd0);
      done = 1'b0;
      @(negedge clk);
      check("nom_load_rdy",  32'(s_if.s_ready), 32'd1);
      check("nom_load_busy", 32'(busy), 32'd0);

      // backpressure gaps, then sticky done
      send_frame(gv, 1'b1);
      check("gap_start", 32'(start), 32'd1);
      check_ops("gap", gv);
      done = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check($sformatf("sticky_start%0d", k), 32'(start), 32'd0);
         check($sformatf("sticky_rdy%0d", k),   32'(s_if.s_ready), 32'd0);
      end
      done = 1'b0;
      @(negedge clk);
      check("sticky_rel_rdy",   32'(s_if.s_ready), 32'd1);
      check("sticky_rel_start", 32'(start), 32'd0);
      @(negedge clk);
      check("sticky_no_restart", 32'(start), 32'd0);

      // timeout after 4 RUN cycles
      send_frame(nom, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("to_run_start%0d", k), 32'(start),   32'd1);
         check($sformatf("to_run_pulse%0d", k), 32'(timeout), 32'd0);
         @(negedge clk);
      end
      check("to_pulse",  32'(timeout), 32'd1);
      check("to_start",  32'(start),   32'd0);
      check("to_busy",   32'(busy),    32'd0);
      check("to_rdy",    32'(s_if.s_ready), 32'd1);
      @(negedge clk);
      check("to_once",   32'(timeout), 32'd0);

      // done arriving in the expiry cycle wins
      send_frame(gv, 1'b0);
      repeat (3) @(negedge clk);
      done = 1'b1;
      @(negedge clk);
      check("exp_no_to",  32'(timeout), 32'd0);
      check("exp_start",  32'(start),   32'd0);
      check("exp_busy",   32'(busy),    32'd1);
      done = 1'b0;
      @(negedge clk);
      check("exp_rdy",    32'(s_if.s_ready), 32'd1);
      check("exp_no_to2", 32'(timeout), 32'd0);

`ifdef MATRIX_LOADER_FRAME_CHECK_EN
      // early s_last on byte 10
      for (int i = 0; i < 10; i++) push(fv[i], (i == 9), 1'b0);
      check("fr_err",     32'(err),   32'd1);
      check("fr_start",   32'(start), 32'd0);
      check("fr_b00_kept", 32'(b00),  32'(gv[9]));
      @(negedge clk);
      check("fr_err_once", 32'(err), 32'd0);
      send_frame(fv, 1'b0);
      check("fr_ok_start", 32'(start), 32'd1);
      check("fr_ok_err",   32'(err),   32'd0);
      check_ops("fr_ok", fv);
      finish_run();
      // missing s_last on the 18th byte
      for (int i = 0; i < 18; i++) push(nom[i], 1'b0, 1'b0);
      check("fr_nolast_err",   32'(err),   32'd1);
      check("fr_nolast_start", 32'(start), 32'd0);
      check("fr_nolast_rdy",   32'(s_if.s_ready), 32'd1);
      check("fr_nolast_b22",   32'(b22),   32'(fv[17]));
      check("fr_nolast_b21",   32'(b21),   32'(nom[16]));
`else
      // s_last is ignored without frame checking
      for (int i = 0; i < 18; i++) push(fv[i], (i == 9), 1'b0);
      check("nf_err",   32'(err),   32'd0);
      check("nf_start", 32'(start), 32'd1);
      check_ops("nf", fv);
      finish_run();
      check("nf_rdy", 32'(s_if.s_ready), 32'd1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
